conv_mac_engine: RTL and testbench
==================================

Name: conv_mac_engine

Overview:
Parametrised multiply-accumulate engine for one convolution output pixel. It accepts TAPS signed (weight, pixel) pairs over a valid/ready stream and accumulates them onto a preloaded bias. It then applies an arithmetic right shift, optional ReLU and signed saturation, and holds the result until acknowledged. It sits between the window/line-buffer feeder and the output pixel writer, and replaces the fixed 3x3/16-bit accumulator.

Parameters:
DATA_W  16  width of signed weight and pixel operands
TAPS  9  products per output pixel (K*K), 1..255
ACC_W  40  internal signed accumulator width, >= 2*DATA_W + ceil(log2(TAPS)) + 1
OUT_W  32  signed output pixel width, <= ACC_W
SHIFT_W  5  width of the requantisation shift amount

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  window enable; low aborts the current pixel
bias  in  ACC_W  signed bias, sampled at window start
shift  in  SHIFT_W  arithmetic right-shift amount, sampled at window start
relu_en  in  1  clamp negative results to 0, sampled at window start
in_valid  in  1  weight/pixel pair valid
in_ready  out  1  engine accepts a pair this cycle
kernel_weights  in  DATA_W  signed weight
in_pix  in  DATA_W  signed input pixel
out_valid  out  1  out_pix holds a completed result
ack  in  1  consumer takes out_pix
out_pix  out  OUT_W  signed result
tap_cnt  out  8  pairs accepted in the current window
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, acc=0, tap_cnt=0, out_valid=0, out_pix=0, in_ready=0, busy=0. Reset overrides every other input, including mid-window and while out_valid is high.
- FSM has three states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=0.
  - If en=1: acc<=bias, latch shift and relu_en, tap_cnt<=0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Accept when in_valid&&in_ready: acc<=acc+sext(w*p). The product is a full signed 2*DATA_W value, sign-extended to ACC_W. tap_cnt increments.
  - in_valid=0 stalls with no change.
  - When the accepted pair is number TAPS (tap_cnt==TAPS-1 at accept):
    - final = acc + product;
    - r = final >>> shift (arithmetic, floor);
    - if relu_en and r<0, then r=0;
    - saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
    - out_pix<=r, out_valid<=1, go to HOLD.
  - Latency: out_valid is high in the cycle after the last pair is accepted.
  - en=0 in ACCUM: abort. Go to IDLE, acc<=0, tap_cnt<=0, no output produced. A pair presented in that same cycle is not accepted (in_ready is forced low combinationally when en=0).
- HOLD:
  - in_ready=0; out_pix and out_valid are held stable until ack=1.
  - On ack: out_valid<=0. If en=1, reload acc<=bias, latch shift and relu_en, go to ACCUM (zero-bubble back-to-back). Otherwise go to IDLE.
  - en=0 while in HOLD does not discard the pending result; it waits for ack.
- ack outside HOLD is ignored.
- The accumulator never wraps within legal parameters; saturation is applied only at the output stage.
- tap_cnt is 0 in IDLE and HOLD after the transition, and counts 0..TAPS-1 in ACCUM.

Test Plan:
- Basic sum: defaults, bias=0, shift=0, relu_en=0; w=1..9, p=2 each, in_valid continuous -> out_valid exactly 1 cycle after the 9th accept, out_pix=90, tap_cnt back to 0.
- Bias and sign: bias=-10, nine pairs w=1, p=1 -> out_pix=-1. Then w=-3, p=100 x9 with bias=0 -> -2700 with relu_en=0; 0 with relu_en=1.
- Saturation and shift: w=p=32767 x9 (sum 9663086601). shift=0 -> out_pix=2147483647. shift=4 -> out_pix=603942912. w=-32768, p=32767 x9, shift=0 -> out_pix=-2147483648.
- Handshake: random in_valid gaps during ACCUM -> result unchanged (90). Hold ack low 5 cycles -> out_valid and out_pix stable, in_ready=0. Then ack with en=1 -> in_ready=1 the next cycle, and the second window gives the correct independent sum.
- Abort: drop en after 4 accepted pairs -> no out_valid, state IDLE. Re-raise en and send the basic-sum vector -> out_pix=90 (no stale partials).
- Reset mid-operation: assert rst in ACCUM after 5 pairs, and separately in HOLD with out_valid=1 -> next cycle out_valid=0, out_pix=0, tap_cnt=0, busy=0. A following window computes correctly.

Source files
------------

// File: rtl/conv_mac_engine.sv
// rtl/conv_mac_engine.sv - signed MAC engine for one convolution output pixel
module conv_mac_engine #(
   parameter int DATA_W  = 16,
   parameter int TAPS    = 9,
   parameter int ACC_W   = 40,
   parameter int OUT_W   = 32,
   parameter int SHIFT_W = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic signed [ACC_W-1:0]   bias,
   input  logic [SHIFT_W-1:0]        shift,
   input  logic                      relu_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  kernel_weights,
   input  logic signed [DATA_W-1:0]  in_pix,
   output logic                      out_valid,
   input  logic                      ack,
   output logic signed [OUT_W-1:0]   out_pix,
   output logic [7:0]                tap_cnt,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [7:0] LAST_TAP = 8'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   state_t                     state;
   logic signed [ACC_W-1:0]    acc;
   logic [SHIFT_W-1:0]         shift_q;
   logic                       relu_q;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    acc_sum;
   logic signed [ACC_W-1:0]    shifted;
   logic signed [OUT_W-1:0]    result;

   // Handshake and status decode; dropping en blocks acceptance in the same cycle
   always_comb begin
      in_ready = (state == ACCUM) && en;
      busy     = (state != IDLE);
   end

   // Datapath: product, running sum and requantised/saturated output value
   always_comb begin
      prod     = kernel_weights * in_pix;
      prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      acc_sum  = acc + prod_ext;
      shifted  = acc_sum >>> shift_q;
      if (relu_q && shifted[ACC_W-1]) begin
         shifted = '0;
      end
      if (shifted > SAT_MAX) begin
         result = SAT_MAX[OUT_W-1:0];
      end else if (shifted < SAT_MIN) begin
         result = SAT_MIN[OUT_W-1:0];
      end else begin
         result = shifted[OUT_W-1:0];
      end
   end

   // Control FSM: window start, accumulation, result hold and abort
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         tap_cnt   <= '0;
         out_valid <= 1'b0;
         out_pix   <= '0;
         shift_q   <= '0;
         relu_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  acc     <= bias;
                  shift_q <= shift;
                  relu_q  <= relu_en;
                  tap_cnt <= '0;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               if (!en) begin
                  acc     <= '0;
                  tap_cnt <= '0;
                  state   <= IDLE;
               end else if (in_valid) begin
                  acc <= acc_sum;
                  if (tap_cnt == LAST_TAP) begin
                     out_pix   <= result;
                     out_valid <= 1'b1;
                     tap_cnt   <= '0;
                     state     <= HOLD;
                  end else begin
                     tap_cnt <= tap_cnt + 8'd1;
                  end
               end
            end
            HOLD: begin
               if (ack) begin
                  out_valid <= 1'b0;
                  if (en) begin
                     acc     <= bias;
                     shift_q <= shift;
                     relu_q  <= relu_en;
                     tap_cnt <= '0;
                     state   <= ACCUM;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb/tb_conv_mac_engine.sv - directed self-checking bench for conv_mac_engine
module tb_conv_mac_engine;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic signed [39:0] bias = '0;
   logic [4:0]         shift = '0;
   logic               relu_en = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] kernel_weights = '0;
   logic signed [15:0] in_pix = '0;
   logic               out_valid;
   logic               ack = 1'b0;
   logic signed [31:0] out_pix;
   logic [7:0]         tap_cnt;
   logic               busy;

   int total = 0;
   int bad = 0;
   logic signed [15:0] wq [0:8];
   logic signed [15:0] pq [0:8];
   bit early_valid;

   conv_mac_engine dut (
      .clk(clk), .rst(rst), .en(en), .bias(bias), .shift(shift), .relu_en(relu_en),
      .in_valid(in_valid), .in_ready(in_ready), .kernel_weights(kernel_weights),
      .in_pix(in_pix), .out_valid(out_valid), .ack(ack), .out_pix(out_pix),
      .tap_cnt(tap_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic set_vec(input logic signed [15:0] w0, input logic signed [15:0] p0, input bit ramp);
      for (int i = 0; i < 9; i++) begin
         wq[i] = ramp ? 16'(i + 1) : w0;
         pq[i] = p0;
      end
   endtask

   // Feed n pairs; ends just after the posedge that accepts the last one
   task automatic feed(input int n, input bit gaps);
      int k = 0;
      int guard = 0;
      bit take;
      early_valid = 1'b0;
      while (k < n && guard < 300) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            kernel_weights = wq[k];
            in_pix = pq[k];
         end
         #1;
         if (out_valid) early_valid = 1'b1;
         take = in_valid && in_ready;
         @(posedge clk);
         if (take) k++;
         guard++;
      end
      total++;
      if (k != n) begin
         bad++;
         $display("FAIL feed_timeout: accepted=%0d required=%0d", k, n);
      end
   endtask

   task automatic run_window(input logic signed [39:0] b, input logic [4:0] s, input logic r, input bit gaps);
      @(negedge clk);
      en = 1'b1; bias = b; shift = s; relu_en = r;
      feed(9, gaps);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_result(input string name, input logic signed [31:0] exp);
      total++;
      if (out_valid !== 1'b1 || early_valid || out_pix !== exp) begin
         bad++;
         $display("FAIL %s: out_valid=%0b early=%0b out_pix=%0d required=%0d", name, out_valid, early_valid, out_pix, exp);
      end
   endtask

   task automatic release_idle();
      ack = 1'b1; en = 1'b0;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_pix !== 32'sd0 || tap_cnt !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset: ov=%0b pix=%0d tap=%0d busy=%0b rdy=%0b required all 0", out_valid, out_pix, tap_cnt, busy, in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      set_vec(0, 2, 1'b1);
      run_window(0, 0, 1'b0, 1'b0);
      check_result("basic_sum", 32'sd90);
      total++;
      if (tap_cnt !== 8'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL basic_hold_state: tap=%0d rdy=%0b busy=%0b required 0/0/1", tap_cnt, in_ready, busy);
      end
      release_idle();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_release: ov=%0b busy=%0b required 0/0", out_valid, busy);
      end
   endtask

   task automatic test_bias_sign();
      set_vec(1, 1, 1'b0);
      run_window(-40'sd10, 0, 1'b0, 1'b0);
      check_result("bias_neg", -32'sd1);
      release_idle();
      set_vec(-3, 100, 1'b0);
      run_window(0, 0, 1'b0, 1'b0);
      check_result("neg_sum", -32'sd2700);
      release_idle();
      run_window(0, 0, 1'b1, 1'b0);
      check_result("relu_clamp", 32'sd0);
      release_idle();
   endtask

   task automatic test_saturation();
      set_vec(32767, 32767, 1'b0);
      run_window(0, 0, 1'b0, 1'b0);
      check_result("sat_pos", 32'sd2147483647);
      release_idle();
      run_window(0, 5'd4, 1'b0, 1'b0);
      check_result("shift4", 32'sd603942912);
      release_idle();
      set_vec(-32768, 32767, 1'b0);
      run_window(0, 0, 1'b0, 1'b0);
      check_result("sat_neg", -32'sd2147483648);
      release_idle();
   endtask

   task automatic test_back_to_back();
      set_vec(0, 2, 1'b1);
      run_window(0, 0, 1'b0, 1'b1);
      check_result("gapped_sum", 32'sd90);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_pix !== 32'sd90 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable: cyc=%0d ov=%0b pix=%0d rdy=%0b required 1/90/0", c, out_valid, out_pix, in_ready);
         end
      end
      set_vec(0, 1, 1'b1);
      bias = 40'sd5;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_ready: rdy=%0b ov=%0b required 1/0", in_ready, out_valid);
      end
      feed(9, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check_result("b2b_second", 32'sd50);
      release_idle();
   endtask

   task automatic test_abort();
      set_vec(0, 2, 1'b1);
      @(negedge clk);
      en = 1'b1; bias = 40'sd1000; shift = 0; relu_en = 1'b0;
      feed(4, 1'b0);
      @(negedge clk);
      total++;
      if (tap_cnt !== 8'd4) begin
         bad++;
         $display("FAIL abort_tapcnt: tap=%0d required 4", tap_cnt);
      end
      en = 1'b0; in_valid = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL abort_ready: rdy=%0b required 0", in_ready);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         total++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || tap_cnt !== 8'd0) begin
            bad++;
            $display("FAIL abort_idle: ov=%0b busy=%0b tap=%0d required 0/0/0", out_valid, busy, tap_cnt);
         end
      end
      run_window(0, 0, 1'b0, 1'b0);
      check_result("after_abort", 32'sd90);
      release_idle();
   endtask

   task automatic test_reset_mid();
      set_vec(0, 2, 1'b1);
      @(negedge clk);
      en = 1'b1; bias = 0; shift = 0; relu_en = 1'b0;
      feed(5, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_pix !== 32'sd0 || tap_cnt !== 8'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_accum: ov=%0b pix=%0d tap=%0d busy=%0b required 0", out_valid, out_pix, tap_cnt, busy);
      end
      run_window(0, 0, 1'b0, 1'b0);
      check_result("pre_rst_hold", 32'sd90);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_pix !== 32'sd0 || tap_cnt !== 8'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_hold: ov=%0b pix=%0d tap=%0d busy=%0b required 0", out_valid, out_pix, tap_cnt, busy);
      end
      set_vec(1, 1, 1'b0);
      run_window(40'sd7, 0, 1'b0, 1'b0);
      check_result("after_rst", 32'sd16);
      release_idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bias_sign();
      test_saturation();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
